// File: rtl/clock_domain_pkg.sv
// Shared constants and helpers for the multi-channel toggle handshake receiver.
package clock_domain_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic int channel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_domain_import_channel.sv
// One handshake channel: req synchronizer, one-word buffer, full flag and ack toggle.
module clock_domain_import_channel
    import clock_domain_pkg::*;
#(
    parameter int SIZE        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] handshake_data,
    input  logic            handshake_req,
    output logic            handshake_ack,
    output logic [SIZE-1:0] buffer,
    output logic            full,
    input  logic            drain
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync;
    logic              pending;
    logic              capture;

    assign pending = sync[STAGES-1] != handshake_ack;
    // A draining buffer frees on this edge, so it can accept the next word at once.
    assign capture = pending && (!full || drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= '0;
            handshake_ack <= 1'b0;
            full          <= 1'b0;
            buffer        <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], handshake_req};
            if (capture) begin
                buffer        <= handshake_data;
                full          <= 1'b1;
                handshake_ack <= sync[STAGES-1];
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_domain_import_mux.sv
// Receives toggle req/ack handshakes on several channels and merges them
// round-robin into one valid/ready stream.
module clock_domain_import_mux
    import clock_domain_pkg::*;
#(
    parameter int SIZE        = 8,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [SIZE-1:0]                     data,
    output logic [channel_width(CHANNELS)-1:0] channel,
    output logic                                valid,
    input  logic                                ready,
    input  logic [CHANNELS*SIZE-1:0]            handshake_data,
    input  logic [CHANNELS-1:0]                 handshake_req,
    output logic [CHANNELS-1:0]                 handshake_ack
);

    localparam int CW = channel_width(CHANNELS);

    logic [SIZE-1:0]     buffer [CHANNELS];
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] drain;
    logic [CW-1:0]       last;
    logic [CW-1:0]       grant;
    logic [CW:0]         idx;
    logic                found;
    logic                load;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        clock_domain_import_channel #(
            .SIZE        (SIZE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .handshake_data (handshake_data[c*SIZE +: SIZE]),
            .handshake_req  (handshake_req[c]),
            .handshake_ack  (handshake_ack[c]),
            .buffer         (buffer[c]),
            .full           (full[c]),
            .drain          (drain[c])
        );
    end

    // One extra bit keeps last+i exact before the wrap, so no index reaches CHANNELS.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = {1'b0, last} + (CW+1)'(i);
            if (idx >= (CW+1)'(CHANNELS)) begin
                idx = idx - (CW+1)'(CHANNELS);
            end
            if (!found && full[idx[CW-1:0]]) begin
                found = 1'b1;
                grant = idx[CW-1:0];
            end
        end
    end

    assign load = !valid || ready;

    always_comb begin
        drain = '0;
        if (load && found) begin
            drain[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            channel <= '0;
            last    <= CW'(CHANNELS - 1);
        end else if (load) begin
            if (found) begin
                valid   <= 1'b1;
                data    <= buffer[grant];
                channel <= grant;
                last    <= grant;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_domain_import_mux.sv
// Scoreboard bench for clock_domain_import_mux (4-channel and 1-channel builds).
module tb_clock_domain_import_mux;

    localparam int SIZE = 8;
    localparam int CH   = 4;

    typedef struct {
        int              ch;
        logic [SIZE-1:0] d;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 ready;
    logic [SIZE-1:0]      data;
    logic [1:0]           channel;
    logic                 valid;
    logic [CH*SIZE-1:0]   hdata;
    logic [CH-1:0]        hreq;
    logic [CH-1:0]        hack;
    logic [SIZE-1:0]      src_data [CH];
    logic                 src_req  [CH];

    logic                 d_ready;
    logic [SIZE-1:0]      d_data;
    logic [0:0]           d_channel;
    logic                 d_valid;
    logic [SIZE-1:0]      d_hdata;
    logic [0:0]           d_req;
    logic [0:0]           d_ack;

    int                   compared   = 0;
    int                   mismatched = 0;
    item_t                exp_q[$];
    int                   order_q[$];
    logic [SIZE-1:0]      d_q[$];
    int                   acc_cnt [CH];
    logic                 done;
    int                   tog;
    int                   midx;
    logic                 hold;
    logic [31:0]          hold_vec;
    logic [31:0]          now_vec;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            hdata[c*SIZE +: SIZE] = src_data[c];
            hreq[c]               = src_req[c];
        end
    end

    clock_domain_import_mux #(
        .SIZE(SIZE), .CHANNELS(CH), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .channel(channel),
        .valid(valid), .ready(ready), .handshake_data(hdata),
        .handshake_req(hreq), .handshake_ack(hack)
    );

    clock_domain_import_mux #(
        .SIZE(SIZE), .CHANNELS(1), .SYNC_STAGES(3)
    ) dut1 (
        .clk(clk), .rst(rst), .data(d_data), .channel(d_channel),
        .valid(d_valid), .ready(d_ready), .handshake_data(d_hdata),
        .handshake_req(d_req), .handshake_ack(d_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CH-1:0] reqv();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = src_req[c];
        return v;
    endfunction

    // Main scoreboard: per-channel FIFO order, optional grant order, hold stability.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            now_vec = {21'b0, valid, channel, data};
            if (hold) check("hold_stable", now_vec, hold_vec);
            if (valid && ready) begin
                midx = -1;
                foreach (exp_q[i]) if (midx < 0 && exp_q[i].ch == int'(channel)) midx = i;
                if (midx < 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got ch%0d data 0x%0h, expected none", channel, data);
                end else begin
                    check($sformatf("data_ch%0d", channel), 32'(data), 32'(exp_q[midx].d));
                    exp_q.delete(midx);
                end
                acc_cnt[channel]++;
                if (order_q.size() > 0) check("grant_order", 32'(channel), 32'(order_q.pop_front()));
            end
            hold     = valid && !ready;
            hold_vec = now_vec;
        end
    end

    always @(negedge clk) begin
        if (!rst && d_valid && d_ready) begin
            if (d_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL d_unexpected: got 0x%0h, expected none", d_data);
            end else begin
                check("d_data", 32'(d_data), 32'(d_q.pop_front()));
            end
            check("d_channel", 32'(d_channel), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int c);
        int n = 0;
        while (src_req[c] !== hack[c] && n < 300) begin
            tick();
            n++;
        end
        check($sformatf("idle_ch%0d", c), 32'(hack[c] == src_req[c]), 1);
    endtask

    task automatic send(input int c, input logic [SIZE-1:0] w);
        wait_idle(c);
        src_data[c] = w;
        src_req[c]  = ~src_req[c];
        exp_q.push_back('{c, w});
    endtask

    task automatic drain_wait();
        int n = 0;
        while (exp_q.size() > 0 && n < 600) begin
            tick();
            n++;
        end
        check("drained", 32'(exp_q.size()), 0);
    endtask

    task automatic stream(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(c, 8'($urandom));
        end
    endtask

    task automatic rr_burst(input logic [3:0] lo);
        logic [CH-1:0] rv;
        logic [CH-1:0] nrv;
        for (int c = 0; c < CH; c++) begin
            src_data[c] = {4'(c + 1), lo};
            src_req[c]  = ~src_req[c];
            exp_q.push_back('{c, {4'(c + 1), lo}});
            order_q.push_back(c);
        end
        rv  = reqv();
        nrv = ~rv;
        for (int k = 1; k <= 8; k++) begin
            after_edge();
            if (k == 2) check("rr_ack_e2", 32'(hack), 32'(nrv));
            if (k == 3) check("rr_ack_e3", 32'(hack), 32'(rv));
            if (k >= 4 && k <= 7) begin
                check("rr_valid", 32'(valid), 1);
                check("rr_channel", 32'(channel), 32'(k - 4));
            end
            if (k == 8) check("rr_idle", 32'(valid), 0);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ready   = 1'b0;
        d_ready = 1'b0;
        d_req   = 1'b0;
        d_hdata = '0;
        for (int c = 0; c < CH; c++) begin
            src_data[c] = '0;
            src_req[c]  = 1'b0;
            acc_cnt[c]  = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid), 0);
        check("rst_ack", 32'(hack), 0);
        check("rst_data", 32'(data), 0);
        check("rst_channel", 32'(channel), 0);
        check("rst_d_valid", 32'(d_valid), 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        ready = 1'b1;
        tick();

        rr_burst(4'h0);
        rr_burst(4'h5);

        repeat (2) tick();
        send(1, 8'hA5);
        order_q.push_back(1);
        for (int k = 1; k <= 5; k++) begin
            after_edge();
            if (k == 2) check("single_ack_e2", 32'(hack[1] == src_req[1]), 0);
            if (k == 3) begin
                check("single_ack_e3", 32'(hack[1] == src_req[1]), 1);
                check("single_valid_e3", 32'(valid), 0);
            end
            if (k == 4) begin
                check("single_valid_e4", 32'(valid), 1);
                check("single_data_e4", 32'(data), 32'h A5);
                check("single_chan_e4", 32'(channel), 1);
            end
            if (k == 5) check("single_valid_e5", 32'(valid), 0);
        end
        tick();

        ready = 1'b0;
        send(0, 8'h11);
        wait_idle(0);
        send(0, 8'h22);
        wait_idle(0);
        send(0, 8'h33);
        repeat (8) tick();
        check("bp_blocked", 32'(hack[0] == src_req[0]), 0);
        check("bp_valid", 32'(valid), 1);
        check("bp_head", 32'(data), 32'h11);
        ready = 1'b1;
        drain_wait();
        wait_idle(0);

        ready = 1'b0;
        send(3, 8'hC1);
        wait_idle(3);
        send(3, 8'hC2);
        wait_idle(3);
        send(3, 8'hC3);
        repeat (6) tick();
        check("mid_valid", 32'(valid), 1);
        check("mid_channel", 32'(channel), 3);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) src_req[c] = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_ack", 32'(hack), 0);
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].ch == 3) exp_q.delete(i);
        exp_q.push_back('{3, 8'hC3});
        ready = 1'b1;
        drain_wait();
        wait_idle(3);
        check("mid_ack3", 32'(hack[3]), 1);
        repeat (10) tick();

        for (int c = 0; c < CH; c++) acc_cnt[c] = 0;
        done = 1'b0;
        fork
            begin
                fork
                    stream(0, 20);
                    stream(2, 20);
                join
                done = 1'b1;
            end
            begin
                tog = 0;
                while (!done && tog < 3000) begin
                    tick();
                    ready = ~ready;
                    tog++;
                end
            end
        join
        ready = 1'b1;
        drain_wait();
        check("fair_cnt0", 32'(acc_cnt[0]), 20);
        check("fair_cnt2", 32'(acc_cnt[2]), 20);

        for (int c = 0; c < CH; c++) acc_cnt[c] = 0;
        done = 1'b0;
        fork
            begin
                fork
                    stream(0, 15);
                    stream(1, 15);
                    stream(2, 15);
                    stream(3, 15);
                join
                done = 1'b1;
            end
            begin
                tog = 0;
                while (!done && tog < 4000) begin
                    tick();
                    ready = ($urandom_range(0, 3) != 0);
                    tog++;
                end
            end
        join
        ready = 1'b1;
        drain_wait();
        for (int c = 0; c < CH; c++) check($sformatf("rand_cnt%0d", c), 32'(acc_cnt[c]), 15);

        d_ready = 1'b1;
        tick();
        d_hdata = 8'h3C;
        d_req   = ~d_req;
        d_q.push_back(8'h3C);
        for (int k = 1; k <= 6; k++) begin
            after_edge();
            if (k == 3) check("d_ack_e3", 32'(d_ack == d_req), 0);
            if (k == 4) begin
                check("d_ack_e4", 32'(d_ack == d_req), 1);
                check("d_valid_e4", 32'(d_valid), 0);
            end
            if (k == 5) check("d_valid_e5", 32'(d_valid), 1);
            if (k == 6) check("d_valid_e6", 32'(d_valid), 0);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            logic [SIZE-1:0] w;
            tog = 0;
            while (d_ack != d_req && tog < 100) begin
                tick();
                tog++;
            end
            check("d_idle", 32'(d_ack == d_req), 1);
            w       = 8'($urandom);
            d_hdata = w;
            d_req   = ~d_req;
            d_q.push_back(w);
        end
        tog = 0;
        while (d_q.size() > 0 && tog < 200) begin
            tick();
            tog++;
        end
        check("d_drained", 32'(d_q.size()), 0);

        repeat (5) tick();
        check("final_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
